// File: rtl/nr_pkg.sv
// Shared constants and reader state encoding for the Newton-Raphson result path.
package nr_pkg;

  localparam int unsigned NR_NWORDS    = 15;
  localparam int unsigned NR_WORD_W    = 32;
  localparam int unsigned NR_IDX_W     = 4;
  localparam int unsigned NR_IDX_X0    = 0;
  localparam int unsigned NR_IDX_INVJ0 = 3;

  typedef enum logic [0:0] {
    NR_RD_IDLE = 1'b0,
    NR_RD_SEND = 1'b1
  } nr_rd_state_e;

endpackage

// File: rtl/nr_result_reader_if.sv
// Capture bus (one-cycle strobe + 15 words) and valid/ready output stream of the result reader.
interface nr_result_reader_if;

  logic                            in_stb;
  logic [nr_pkg::NR_WORD_W-1:0]    in_x0, in_x1, in_x2;
  logic [nr_pkg::NR_WORD_W-1:0]    in_invJ0, in_invJ1, in_invJ2,  in_invJ3;
  logic [nr_pkg::NR_WORD_W-1:0]    in_invJ4, in_invJ5, in_invJ6,  in_invJ7;
  logic [nr_pkg::NR_WORD_W-1:0]    in_invJ8, in_invJ9, in_invJ10, in_invJ11;

  logic [nr_pkg::NR_WORD_W-1:0]    out_data;
  logic [nr_pkg::NR_IDX_W-1:0]     out_idx;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;

  // Reader side: consumes the capture bus, sources the stream.
  modport master (
    input  in_stb, in_x0, in_x1, in_x2,
           in_invJ0, in_invJ1, in_invJ2, in_invJ3, in_invJ4, in_invJ5,
           in_invJ6, in_invJ7, in_invJ8, in_invJ9, in_invJ10, in_invJ11,
           out_ready,
    output out_data, out_idx, out_valid, out_last
  );

  // Environment side: iteration core plus stream sink.
  modport slave (
    output in_stb, in_x0, in_x1, in_x2,
           in_invJ0, in_invJ1, in_invJ2, in_invJ3, in_invJ4, in_invJ5,
           in_invJ6, in_invJ7, in_invJ8, in_invJ9, in_invJ10, in_invJ11,
           out_ready,
    input  out_data, out_idx, out_valid, out_last
  );

endinterface

// File: rtl/nr_word_mux.sv
// 16:1 word selector over the shadow array; the select is expected to come from a flop.
module nr_word_mux
  import nr_pkg::*;
(
  input  logic [15:0][NR_WORD_W-1:0] i_words,
  input  logic [NR_IDX_W-1:0]        i_sel,
  output logic [NR_WORD_W-1:0]       o_word_c
);

  assign o_word_c = i_words[i_sel];

endmodule

// File: rtl/nr_result_reader.sv
// Captures one Newton-Raphson result frame on in_stb and replays it on a valid/ready stream.
// Optional NR_READER_CHECKSUM_EN appends an XOR word at index 15.
module nr_result_reader
  import nr_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nr_result_reader_if.master     bus,
  input  logic                   ovf_clr,
  output logic                   busy,
  output logic                   overflow,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef NR_READER_CHECKSUM_EN
  localparam logic [NR_IDX_W-1:0] LAST = NR_IDX_W'(15);
`else
  localparam logic [NR_IDX_W-1:0] LAST = NR_IDX_W'(14);
`endif

  localparam logic [0:0] ST_IDLE = NR_RD_IDLE;
  localparam logic [0:0] ST_SEND = NR_RD_SEND;

  logic [0:0]                        r_state, w_state_nxt;
  logic [NR_IDX_W-1:0]               r_idx, w_idx_nxt;
  logic                              r_valid, w_valid_nxt;
  logic                              r_last, w_last_nxt;
  logic                              r_ovf, w_ovf_nxt;
  logic [FRAME_CNT_W-1:0]            r_frame_cnt, w_cnt_nxt;
  logic                              w_hs, w_load, w_ovf_set;
  logic [15:0][NR_WORD_W-1:0]        r_shadow;
  logic [NR_NWORDS-1:0][NR_WORD_W-1:0] w_cap;

  // Word order: x0..x2 first, then invJ0..invJ11 (concatenation is MSB-first).
  assign w_cap = {bus.in_invJ11, bus.in_invJ10, bus.in_invJ9, bus.in_invJ8,
                  bus.in_invJ7,  bus.in_invJ6,  bus.in_invJ5, bus.in_invJ4,
                  bus.in_invJ3,  bus.in_invJ2,  bus.in_invJ1, bus.in_invJ0,
                  bus.in_x2,     bus.in_x1,     bus.in_x0};

`ifdef NR_READER_CHECKSUM_EN
  logic [NR_WORD_W-1:0] w_xor;

  // Checksum is folded from the live inputs so it lands in the shadow with the frame.
  always_comb begin
    w_xor = '0;
    for (int i = 0; i < int'(NR_NWORDS); i++) begin
      w_xor = w_xor ^ w_cap[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
    end else if (w_load) begin
      r_shadow[NR_NWORDS-1:0] <= w_cap;
`ifdef NR_READER_CHECKSUM_EN
      r_shadow[15] <= w_xor;
`endif
    end
  end

  // Next-state: a strobe is only accepted while idle or on the final handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_frame_cnt;
    w_load      = 1'b0;
    w_ovf_set   = 1'b0;
    w_hs        = r_valid & bus.out_ready;

    if (r_state == ST_IDLE) begin
      if (bus.in_stb) begin
        w_load      = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = ST_SEND;
      end
    end else begin
      if (w_hs && (r_idx == LAST)) begin
        w_cnt_nxt = r_frame_cnt + FRAME_CNT_W'(1);
        w_idx_nxt = '0;
        if (bus.in_stb) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end else begin
        if (w_hs) begin
          w_idx_nxt = r_idx + NR_IDX_W'(1);
        end
        if (bus.in_stb) begin
          w_ovf_set = 1'b1;
        end
      end
    end

    w_ovf_nxt   = w_ovf_set | (r_ovf & ~ovf_clr);
    w_valid_nxt = (w_state_nxt == ST_SEND);
    w_last_nxt  = w_valid_nxt && (w_idx_nxt == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
      r_ovf       <= w_ovf_nxt;
      r_frame_cnt <= w_cnt_nxt;
    end
  end

  nr_word_mux u_word_mux (
    .i_words  (r_shadow),
    .i_sel    (r_idx),
    .o_word_c (bus.out_data)
  );

  assign bus.out_idx   = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign busy          = (r_state == ST_SEND);
  assign overflow      = r_ovf;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_nr_result_reader.sv
// Directed bench for nr_result_reader: streaming, backpressure, drop, back-to-back, async reset.
module tb_nr_result_reader;

`ifdef NR_READER_CHECKSUM_EN
  localparam int LAST = 15;
`else
  localparam int LAST = 14;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ovf_clr;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] fa [16];
  logic [31:0] fb [16];
  logic [31:0] fc [16];
  logic [31:0] fd [16];
  logic [31:0] fe [16];

  nr_result_reader_if bus ();

  nr_result_reader #(.FRAME_CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] f [16], input int k);
    chk($sformatf("%s_valid%0d", tag, k), 32'(bus.out_valid), 32'd1);
    chk($sformatf("%s_idx%0d",   tag, k), 32'(bus.out_idx),   32'(k));
    chk($sformatf("%s_data%0d",  tag, k), bus.out_data,       f[k]);
    chk($sformatf("%s_last%0d",  tag, k), 32'(bus.out_last),  32'(k == LAST));
  endtask

  task automatic put(input logic [31:0] f [16]);
    bus.in_x0     = f[0];  bus.in_x1     = f[1];  bus.in_x2     = f[2];
    bus.in_invJ0  = f[3];  bus.in_invJ1  = f[4];  bus.in_invJ2  = f[5];
    bus.in_invJ3  = f[6];  bus.in_invJ4  = f[7];  bus.in_invJ5  = f[8];
    bus.in_invJ6  = f[9];  bus.in_invJ7  = f[10]; bus.in_invJ8  = f[11];
    bus.in_invJ9  = f[12]; bus.in_invJ10 = f[13]; bus.in_invJ11 = f[14];
  endtask

  task automatic start(input logic [31:0] f [16]);
    put(f);
    bus.in_stb = 1'b1;
    tick();
    bus.in_stb = 1'b0;
  endtask

  task automatic stream(input string tag, input logic [31:0] f [16]);
    for (int k = 0; k <= LAST; k++) begin
      chk_word(tag, f, k);
      tick();
    end
  endtask

  initial begin
    int c;
    fa[0] = 32'h3F800000; fa[1] = 32'h40000000; fa[2] = 32'h40400000;
    for (int k = 0; k < 12; k++) fa[3+k] = 32'h00000100 + 32'(k);
    for (int k = 0; k < 15; k++) begin
      fb[k] = 32'hB0000000 | (32'(k) << 4);
      fc[k] = 32'hC0DE0000 + 32'(k);
      fd[k] = fa[k];
      fe[k] = 32'(k + 1);
    end
    fd[0] = 32'hDEADBEEF;
    fa[15] = '0; fb[15] = '0; fc[15] = '0; fd[15] = '0; fe[15] = '0;
    for (int k = 0; k < 15; k++) begin
      fa[15] ^= fa[k]; fb[15] ^= fb[k]; fc[15] ^= fc[k]; fd[15] ^= fd[k]; fe[15] ^= fe[k];
    end

    rst = 1'b0; ovf_clr = 1'b0; bus.in_stb = 1'b0; bus.out_ready = 1'b1;
    put(fe);
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last",  32'(bus.out_last),  32'd0);
    chk("rst_data",  bus.out_data,       32'd0);
    chk("rst_idx",   32'(bus.out_idx),   32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_cnt",   32'(frame_cnt),     32'd0);
    rst = 1'b1;
    tick();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // Single frame, ready held high.
    start(fa);
    chk("a_busy", 32'(busy), 32'd1);
    stream("a", fa);
    chk("a_done_valid", 32'(bus.out_valid), 32'd0);
    chk("a_done_busy",  32'(busy),          32'd0);
    chk("a_cnt",        32'(frame_cnt),     32'd1);

    // Backpressure: ready high one cycle in three.
    start(fb);
    c = 0;
    for (int k = 0; k <= LAST; k++) begin
      for (int s = 0; s < 3; s++) begin
        bus.out_ready = (c % 3 == 2);
        c++;
        chk_word("bp", fb, k);
        tick();
        if (bus.out_ready) break;
      end
    end
    bus.out_ready = 1'b1;
    chk("bp_cnt",   32'(frame_cnt),     32'd2);
    chk("bp_valid", 32'(bus.out_valid), 32'd0);

    // Dropped strobe mid-frame, then set-vs-clear priority, then clear.
    start(fa);
    chk("drop_ovf0", 32'(overflow), 32'd0);
    for (int k = 0; k <= LAST; k++) begin
      chk_word("drop", fa, k);
      if (k == 5) begin put(fd); bus.in_stb = 1'b1; end
      if (k == 8) begin bus.in_stb = 1'b1; ovf_clr = 1'b1; end
      tick();
      bus.in_stb = 1'b0; ovf_clr = 1'b0;
      if (k == 5) chk("drop_ovf_set", 32'(overflow), 32'd1);
      if (k == 8) chk("ovf_set_wins", 32'(overflow), 32'd1);
    end
    chk("drop_cnt",  32'(frame_cnt), 32'd3);
    chk("drop_busy", 32'(busy),      32'd0);
    chk("drop_ovf",  32'(overflow),  32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Back-to-back: new strobe on the final handshake cycle.
    start(fa);
    for (int k = 0; k <= LAST; k++) begin
      chk_word("b2b_a", fa, k);
      if (k == LAST) begin put(fb); bus.in_stb = 1'b1; end
      tick();
      bus.in_stb = 1'b0;
    end
    chk("b2b_cnt1", 32'(frame_cnt), 32'd4);
    chk("b2b_ovf",  32'(overflow),  32'd0);
    stream("b2b_b", fb);
    chk("b2b_cnt2",  32'(frame_cnt),     32'd5);
    chk("b2b_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of a frame.
    start(fc);
    for (int k = 0; k < 7; k++) begin
      chk_word("pre_rst", fc, k);
      tick();
    end
    chk_word("pre_rst", fc, 7);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_idx",   32'(bus.out_idx),   32'd0);
    chk("arst_data",  bus.out_data,       32'd0);
    chk("arst_last",  32'(bus.out_last),  32'd0);
    chk("arst_busy",  32'(busy),          32'd0);
    chk("arst_cnt",   32'(frame_cnt),     32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    start(fa);
    stream("post_rst", fa);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // Frame of small integers; with the checksum build idx 15 carries their XOR.
    start(fe);
    stream("ck", fe);
    chk("ck_cnt", 32'(frame_cnt), 32'd2);
    chk("ck_ovf", 32'(overflow),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
